// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: sequencer state
// encoding and the default operand/bus width used by sequencer and datapath.
package mul_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Handshake, operand and datapath-control bundle between the multiplier
// sequencer (master) and its host/datapath side (slave).
interface mul_sequencer_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             abort;
  logic             eqz;
  logic [WIDTH-1:0] data_in;
  logic             LdA;
  logic             LdB;
  logic             LdP;
  logic             clrP;
  logic             decB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] iter_count;

  modport master (
    input  start_valid, op_a, op_b, abort, eqz,
    output start_ready, data_in, LdA, LdB, LdP, clrP, decB, busy, done, iter_count
  );

  modport slave (
    output start_valid, op_a, op_b, abort, eqz,
    input  start_ready, data_in, LdA, LdB, LdP, clrP, decB, busy, done, iter_count
  );

endinterface

// File: rtl/mul_op_latch.sv
// Operand holding registers for the multiplier sequencer and the mux that
// places A or B onto the shared datapath bus (zero when neither is selected).
module mul_op_latch
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             sel_a_i,
  input  logic             sel_b_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = op_a_i;
      b_d = op_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  always_comb begin
    data_o = '0;
    if (sel_a_i)      data_o = a_q;
    else if (sel_b_i) data_o = b_q;
  end

endmodule

// File: rtl/mul_sequencer.sv
// Control sequencer for the repeated-addition multiplier: loads A and B onto
// the datapath, steps the accumulate loop until eqz, then pulses done.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  mul_sequencer_if.master seq_io
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] iter_count_q, iter_count_d;
  logic             accept;
  logic             calc_step;
  logic             sel_a;
  logic             sel_b;

  // A handshake coinciding with reset is never taken.
  assign accept    = seq_io.start_valid && (state_q == IDLE) && !rst;
  assign calc_step = (state_q == CALC) && !seq_io.eqz && !seq_io.abort;
  assign sel_a     = (state_q == LOAD_A) && !seq_io.abort;
  assign sel_b     = (state_q == LOAD_B) && !seq_io.abort;

  mul_op_latch #(
    .WIDTH (WIDTH)
  ) u_op_latch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .op_a_i  (seq_io.op_a),
    .op_b_i  (seq_io.op_b),
    .sel_a_i (sel_a),
    .sel_b_i (sel_b),
    .data_o  (seq_io.data_in)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD_A;
      LOAD_A:  state_d = seq_io.abort ? IDLE : LOAD_B;
      LOAD_B:  state_d = seq_io.abort ? IDLE : CALC;
      CALC: begin
        if (seq_io.abort)    state_d = IDLE;
        else if (seq_io.eqz) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LdP/decB are Mealy on eqz so the loop never issues an extra accumulate.
  always_comb begin
    seq_io.start_ready = 1'b0;
    seq_io.busy        = 1'b1;
    seq_io.done        = 1'b0;
    seq_io.LdA         = 1'b0;
    seq_io.LdB         = 1'b0;
    seq_io.clrP        = 1'b0;
    seq_io.LdP         = 1'b0;
    seq_io.decB        = 1'b0;
    case (state_q)
      IDLE: begin
        seq_io.start_ready = 1'b1;
        seq_io.busy        = 1'b0;
      end
      LOAD_A:  seq_io.LdA = sel_a;
      LOAD_B: begin
        seq_io.LdB  = sel_b;
        seq_io.clrP = sel_b;
      end
      CALC: begin
        seq_io.LdP  = calc_step;
        seq_io.decB = calc_step;
      end
      DONE:    seq_io.done = 1'b1;
      default: seq_io.busy = 1'b0;
    endcase
  end

  always_comb begin
    iter_count_d = iter_count_q;
    if (accept)         iter_count_d = '0;
    else if (calc_step) iter_count_d = iter_count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) iter_count_q <= '0;
    else     iter_count_q <= iter_count_d;
  end

  assign seq_io.iter_count = iter_count_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer driving a behavioural repeated-addition
// datapath; products, latencies and pulse counts are hand-computed.
module tb_mul_sequencer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_io (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: A, B counter, P accumulator (never reset).
  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [W-1:0] dp_p = '0;

  always_ff @(posedge clk) begin
    if (bus.LdA) dp_a <= bus.data_in;
    if (bus.LdB)       dp_b <= bus.data_in;
    else if (bus.decB) dp_b <= dp_b - 16'd1;
    if (bus.LdP)       dp_p <= dp_p + dp_a;
    else if (bus.clrP) dp_p <= '0;
  end

  assign bus.eqz = (dp_b == '0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {bus.LdA, bus.LdB, bus.clrP, bus.LdP, bus.decB};
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "/ready"}, bus.start_ready, 1);
    chk({tag, "/busy"},  bus.busy, 0);
    chk({tag, "/done"},  bus.done, 0);
    chk({tag, "/bus"},   bus.data_in, 0);
    chk({tag, "/strb"},  strobes(), 0);
    chk({tag, "/iter"},  bus.iter_count, 0);
  endtask

  // Called with the sequencer in IDLE; handshake happens in the current cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_p);
    int cyc  = 0;
    int ldp  = 0;
    int decb = 0;
    bit sr_high = 1'b0;
    bus.start_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    step();
    bus.start_valid = 1'b0;
    bus.op_a = 16'hdead;
    bus.op_b = 16'hbeef;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      if (cyc == 1) chk({tag, "/loada"}, {bus.LdA, bus.data_in}, {1'b1, a});
      if (cyc == 2) chk({tag, "/loadb"}, {strobes(), bus.data_in}, {5'b01100, b});
      if (bus.start_ready) sr_high = 1'b1;
      if (bus.LdP) ldp++;
      if (bus.decB) decb++;
      step();
      cyc++;
    end
    if (bus.start_ready) sr_high = 1'b1;
    chk({tag, "/lat"},  cyc, 32'(b) + 4);
    chk({tag, "/P"},    dp_p, exp_p);
    chk({tag, "/iter"}, bus.iter_count, b);
    chk({tag, "/ldp"},  ldp, b);
    chk({tag, "/decb"}, decb, b);
    chk({tag, "/rdy0"}, sr_high, 0);
    step();
    chk({tag, "/rdy1"}, {bus.start_ready, bus.done}, 2'b10);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.abort = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    run_op("7x5", 16'd7, 16'd5, 16'd35);
    run_op("9x0", 16'd9, 16'd0, 16'd0);
    run_op("wrap", 16'h1000, 16'h0011, 16'h1000);
    run_op("0x6", 16'd0, 16'd6, 16'd0);

    // Abort during LOAD_B
    bus.start_valid = 1'b1; bus.op_a = 16'd5; bus.op_b = 16'd5;
    step();
    bus.start_valid = 1'b0;
    step();
    bus.abort = 1'b1;
    #1;
    chk("abB/strb", strobes(), 0);
    chk("abB/bus", bus.data_in, 0);
    step();
    bus.abort = 1'b0;
    chk("abB/idle", {bus.start_ready, bus.busy, bus.done}, 3'b100);

    // Abort in the third CALC cycle of 4x10
    bus.start_valid = 1'b1; bus.op_a = 16'd4; bus.op_b = 16'd10;
    step();
    bus.start_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.abort = 1'b1;
    #1;
    chk("abC/strb", strobes(), 0);
    chk("abC/bus", bus.data_in, 0);
    chk("abC/iter", bus.iter_count, 2);
    step();
    bus.abort = 1'b0;
    chk("abC/idle", {bus.start_ready, bus.busy, bus.done}, 3'b100);
    chk("abC/iter2", bus.iter_count, 2);
    run_op("3x3", 16'd3, 16'd3, 16'd9);

    // Reset mid-CALC together with a handshake attempt
    bus.start_valid = 1'b1; bus.op_a = 16'd4; bus.op_b = 16'd10;
    step();
    bus.start_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rstC/incalc", bus.LdP, 1);
    rst = 1'b1;
    bus.start_valid = 1'b1; bus.op_a = 16'd1; bus.op_b = 16'd1;
    step();
    check_idle_outputs("rstC");
    rst = 1'b0;
    bus.start_valid = 1'b0;
    step();
    chk("rstC/ign", {bus.start_ready, bus.LdA}, 2'b10);

    // Back-to-back: start_valid held high through the first operation
    begin
      int  cyc = 1;
      bit  sr_high = 1'b0;
      bit  saw_done = 1'b0;
      bus.start_valid = 1'b1; bus.op_a = 16'd2; bus.op_b = 16'd3;
      step();
      bus.op_a = 16'd6; bus.op_b = 16'd2;
      while (!bus.start_ready && cyc < 100) begin
        if (bus.done) begin
          saw_done = 1'b1;
          chk("b2b/P1", dp_p, 6);
        end
        step();
        cyc++;
      end
      chk("b2b/acc", cyc, 8);
      chk("b2b/done1", saw_done, 1);
      step();
      bus.start_valid = 1'b0;
      cyc = 1;
      while (!bus.done && cyc < 100) begin
        if (bus.start_ready) sr_high = 1'b1;
        step();
        cyc++;
      end
      chk("b2b/lat2", cyc, 6);
      chk("b2b/P2", dp_p, 12);
      chk("b2b/rdy0", sr_high, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
